// File: rtl/branch_resolve_if.sv
// Fetch lookup, execute resolution and registered result bundle of the branch resolve unit.
// The master drives fetch/execute inputs; the slave (the unit) returns prediction and results.
interface branch_resolve_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    logic [DATA_WIDTH-1:0] lookup_pc;
    logic                  lookup_pred;
    logic                  ex_valid;
    logic [2:0]            ex_funct3;
    logic [DATA_WIDTH-1:0] ex_rs1;
    logic [DATA_WIDTH-1:0] ex_rs2;
    logic [DATA_WIDTH-1:0] ex_pc;
    logic [DATA_WIDTH-1:0] ex_imm;
    logic                  ex_pred_taken;
    logic                  res_valid;
    logic                  res_taken;
    logic                  res_mispredict;
    logic                  res_illegal;
    logic [DATA_WIDTH-1:0] res_redirect_pc;
    logic [CNT_WIDTH-1:0]  mispredict_cnt;

    modport master (
        output lookup_pc, ex_valid, ex_funct3, ex_rs1, ex_rs2, ex_pc, ex_imm, ex_pred_taken,
        input  lookup_pred, res_valid, res_taken, res_mispredict, res_illegal,
               res_redirect_pc, mispredict_cnt
    );

    modport slave (
        input  lookup_pc, ex_valid, ex_funct3, ex_rs1, ex_rs2, ex_pc, ex_imm, ex_pred_taken,
        output lookup_pred, res_valid, res_taken, res_mispredict, res_illegal,
               res_redirect_pc, mispredict_cnt
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// RISC-V conditional branch resolution with a bimodal 2-bit-counter BHT,
// one-cycle registered result and a saturating mispredict statistic.
module branch_resolve_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int BHT_DEPTH  = 64,
    parameter int CNT_WIDTH  = 16
) (
    input  logic            clk,
    input  logic            rst,
    branch_resolve_if.slave bus
);
    localparam int BHT_IDX = $clog2(BHT_DEPTH);

    logic [1:0]         bht [BHT_DEPTH];
    logic [BHT_IDX-1:0] lookup_idx;
    logic [BHT_IDX-1:0] ex_idx;
    logic [1:0]         ctr;
    logic [1:0]         ctr_next;
    logic               legal;
    logic               taken;
    logic               mispredict;
    logic               unused_lookup_bits;

    assign lookup_idx      = bus.lookup_pc[BHT_IDX+1:2];
    assign ex_idx          = bus.ex_pc[BHT_IDX+1:2];
    assign bus.lookup_pred = bht[lookup_idx][1];
    assign unused_lookup_bits = ^{bus.lookup_pc[DATA_WIDTH-1:BHT_IDX+2], bus.lookup_pc[1:0]};

    always_comb begin
        legal = 1'b1;
        taken = 1'b0;
        case (bus.ex_funct3)
            3'b000:  taken = (bus.ex_rs1 == bus.ex_rs2);
            3'b001:  taken = (bus.ex_rs1 != bus.ex_rs2);
            3'b100:  taken = ($signed(bus.ex_rs1) <  $signed(bus.ex_rs2));
            3'b101:  taken = ($signed(bus.ex_rs1) >= $signed(bus.ex_rs2));
            3'b110:  taken = (bus.ex_rs1 <  bus.ex_rs2);
            3'b111:  taken = (bus.ex_rs1 >= bus.ex_rs2);
            default: legal = 1'b0;
        endcase
    end

    // Saturating 2-bit counter step for the entry being resolved
    always_comb begin
        ctr      = bht[ex_idx];
        ctr_next = ctr;
        if (taken) begin
            if (ctr != 2'b11) ctr_next = ctr + 2'd1;
        end else begin
            if (ctr != 2'b00) ctr_next = ctr - 2'd1;
        end
    end

    assign mispredict = bus.ex_valid & legal & (taken != bus.ex_pred_taken);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'b01;
            bus.res_valid       <= 1'b0;
            bus.res_taken       <= 1'b0;
            bus.res_mispredict  <= 1'b0;
            bus.res_illegal     <= 1'b0;
            bus.res_redirect_pc <= '0;
            bus.mispredict_cnt  <= '0;
        end else begin
            bus.res_valid      <= bus.ex_valid;
            bus.res_taken      <= bus.ex_valid & taken;
            bus.res_mispredict <= mispredict;
            bus.res_illegal    <= bus.ex_valid & ~legal;
            // Redirect holds its last value across idle cycles
            if (bus.ex_valid) begin
                bus.res_redirect_pc <= taken ? (bus.ex_pc + bus.ex_imm)
                                             : (bus.ex_pc + DATA_WIDTH'(4));
            end
            if (bus.ex_valid && legal) bht[ex_idx] <= ctr_next;
            if (mispredict && (bus.mispredict_cnt != {CNT_WIDTH{1'b1}})) begin
                bus.mispredict_cnt <= bus.mispredict_cnt + CNT_WIDTH'(1);
            end
        end
    end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed plan steps plus random vectors against a behavioural model.
module tb_branch_resolve_unit;
    localparam int DW    = 32;
    localparam int DEPTH = 64;
    localparam int CW    = 4;
    localparam int CMAX  = 15;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    branch_resolve_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();
    branch_resolve_unit #(.DATA_WIDTH(DW), .BHT_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int vectors = 0;
    int miscompares = 0;

    int            m_bht [DEPTH];
    int            m_cnt;
    logic [DW-1:0] m_redir;
    logic          e_valid, e_taken, e_mis, e_ill;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int idx_of(logic [DW-1:0] pc);
        return int'((pc / 4) % DEPTH);
    endfunction

    function automatic longint sval(logic [DW-1:0] v);
        return v[DW-1] ? longint'(v) - (longint'(1) << DW) : longint'(v);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_bht[i] = 1;
        m_cnt = 0; m_redir = '0;
        e_valid = 0; e_taken = 0; e_mis = 0; e_ill = 0;
    endtask

    task automatic drive(logic v, logic [2:0] f3, logic [DW-1:0] a, logic [DW-1:0] b,
                         logic [DW-1:0] pc, logic [DW-1:0] imm, logic pred);
        bus.ex_valid = v; bus.ex_funct3 = f3; bus.ex_rs1 = a; bus.ex_rs2 = b;
        bus.ex_pc = pc; bus.ex_imm = imm; bus.ex_pred_taken = pred;
    endtask

    task automatic check_results(string tag);
        check({tag, ".valid"},    64'(bus.res_valid),       64'(e_valid));
        check({tag, ".taken"},    64'(bus.res_taken),       64'(e_taken));
        check({tag, ".mispred"},  64'(bus.res_mispredict),  64'(e_mis));
        check({tag, ".illegal"},  64'(bus.res_illegal),     64'(e_ill));
        check({tag, ".redirect"}, 64'(bus.res_redirect_pc), 64'(m_redir));
        check({tag, ".cnt"},      64'(bus.mispredict_cnt),  64'(m_cnt));
    endtask

    // Predicts the outcome from the ISA rules, advances the model, then clocks the DUT and compares.
    task automatic step(string tag);
        logic tk, lg;
        int   i;
        tk = 0; lg = 1;
        case (bus.ex_funct3)
            3'd0: tk = (bus.ex_rs1 == bus.ex_rs2);
            3'd1: tk = (bus.ex_rs1 != bus.ex_rs2);
            3'd4: tk = (sval(bus.ex_rs1) <  sval(bus.ex_rs2));
            3'd5: tk = (sval(bus.ex_rs1) >= sval(bus.ex_rs2));
            3'd6: tk = (longint'(bus.ex_rs1) <  longint'(bus.ex_rs2));
            3'd7: tk = (longint'(bus.ex_rs1) >= longint'(bus.ex_rs2));
            default: lg = 0;
        endcase
        if (bus.ex_valid) begin
            e_valid = 1; e_taken = tk; e_ill = !lg; e_mis = lg && (tk != bus.ex_pred_taken);
            m_redir = tk ? bus.ex_pc + bus.ex_imm : bus.ex_pc + 32'd4;
            i = idx_of(bus.ex_pc);
            if (lg) m_bht[i] = tk ? ((m_bht[i] < 3) ? m_bht[i] + 1 : 3)
                                  : ((m_bht[i] > 0) ? m_bht[i] - 1 : 0);
            if (e_mis && m_cnt < CMAX) m_cnt++;
        end else begin
            e_valid = 0; e_taken = 0; e_mis = 0; e_ill = 0;
        end
        @(posedge clk);
        #1;
        check_results(tag);
    endtask

    task automatic check_lookup(string tag, logic [DW-1:0] pc);
        bus.lookup_pc = pc;
        #1;
        check(tag, 64'(bus.lookup_pred), 64'(m_bht[idx_of(pc)] >= 2));
    endtask

    initial begin : main
        logic [DW-1:0] pool [6];
        logic [DW-1:0] a, b, pc;
        int            all_zero;

        model_reset();
        drive(0, 3'd0, '0, '0, '0, '0, 0);
        bus.lookup_pc = '0;

        // Reset and initial state
        #2 rst = 1'b1;
        #1 check_results("rst_async");
        @(negedge clk) rst = 1'b0;
        all_zero = 1;
        for (int i = 0; i < DEPTH; i++) begin
            bus.lookup_pc = DW'(i * 4);
            #0.1;
            if (bus.lookup_pred !== 1'b0) all_zero = 0;
        end
        check("rst_lookup_sweep", 64'(all_zero), 64'd1);
        @(posedge clk); #1;
        check_results("post_rst");

        // Signed vs unsigned less-than on the same operands
        drive(1, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'hFFFF_FFF0, 0);
        step("blt");
        check("blt_redirect_const", 64'(bus.res_redirect_pc), 64'h0000_00F0);
        check("blt_cnt_const", 64'(bus.mispredict_cnt), 64'd1);
        drive(1, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'hFFFF_FFF0, 0);
        step("bltu");
        check("bltu_redirect_const", 64'(bus.res_redirect_pc), 64'h0000_0104);

        // Training and saturation of one BHT entry, both directions
        bus.lookup_pc = 32'h40;
        for (int k = 0; k < 4; k++) begin
            drive(1, 3'b000, 32'd5, 32'd5, 32'h40, 32'h20, bus.lookup_pred);
            step("beq_t");
            check_lookup("beq_t_pred", 32'h40);
        end
        for (int k = 0; k < 4; k++) begin
            drive(1, 3'b000, 32'd5, 32'd6, 32'h40, 32'h20, 1);
            step("beq_nt");
            check_lookup("beq_nt_pred", 32'h40);
        end
        check("sat_low_const", 64'(bus.lookup_pred), 64'd0);

        // Illegal encoding leaves BHT and statistic untouched
        drive(1, 3'b010, 32'd5, 32'd5, 32'h40, 32'h20, 1);
        step("illegal");
        check("illegal_redirect_const", 64'(bus.res_redirect_pc), 64'h44);
        check_lookup("illegal_bht", 32'h40);

        // Redirect wrap-around
        drive(1, 3'b001, 32'd1, 32'd2, 32'hFFFF_FFFC, 32'd8, 1);
        step("wrap_t");
        drive(1, 3'b001, 32'd3, 32'd3, 32'hFFFF_FFFC, 32'd8, 0);
        step("wrap_nt");

        // Idle cycle holds redirect
        drive(0, 3'b000, 32'd1, 32'd1, 32'h200, 32'h10, 1);
        step("idle");

        // Random traffic; lookup sampled before the edge exposes any bypass
        pool[0] = 32'h0; pool[1] = 32'h1; pool[2] = 32'hFFFF_FFFF;
        pool[3] = 32'h8000_0000; pool[4] = 32'h7FFF_FFFF;
        for (int k = 0; k < 150; k++) begin
            pool[5] = $urandom;
            a  = pool[$urandom_range(0, 5)];
            b  = ($urandom_range(0, 3) == 0) ? a : pool[$urandom_range(0, 5)];
            pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + DW'($urandom_range(0, 15))
                                             : DW'($urandom_range(0, 1023));
            drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), a, b, pc,
                  $urandom, 1'($urandom_range(0, 1)));
            check_lookup("rnd_lookup", ($urandom_range(0, 1) == 1) ? pc : DW'($urandom_range(0, 1023)));
            step("rnd");
        end

        // Asynchronous reset mid-cycle with a branch in flight
        drive(1, 3'b000, 32'd7, 32'd7, 32'h80, 32'h40, 0);
        #3 rst = 1'b1;
        model_reset();
        #1 check_results("mid_rst_async");
        @(posedge clk); #1;
        check_results("mid_rst_discard");
        all_zero = 1;
        for (int i = 0; i < DEPTH; i++) begin
            bus.lookup_pc = DW'(i * 4);
            #0.1;
            if (bus.lookup_pred !== 1'b0) all_zero = 0;
        end
        check("mid_rst_lookup_sweep", 64'(all_zero), 64'd1);
        drive(0, 3'b000, '0, '0, '0, '0, 0);
        @(negedge clk) rst = 1'b0;

        // Single taken update proves entries restart from weak-NT
        drive(1, 3'b000, 32'd7, 32'd7, 32'h80, 32'h40, 1);
        step("reinit");
        check_lookup("reinit_pred", 32'h80);

        // Statistic saturation over back-to-back mispredicts
        for (int k = 0; k < 20; k++) begin
            drive(1, 3'b101, DW'(k), 32'd0, DW'(k * 4), 32'h10, 0);
            step("sat_cnt");
        end
        check("sat_cnt_const", 64'(bus.mispredict_cnt), 64'hF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
